// File: rtl/mips_mon_pkg.sv
// Shared types and constants for the MIPS store-result monitor: FSM states, test IDs,
// memwrite encodings and the end-of-program signature table.
package mips_mon_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } mon_state_t;

    typedef enum logic [1:0] {
        ID_NONE      = 2'd0,
        ID_STANDARD2 = 2'd1,
        ID_POWER2    = 2'd2,
        ID_LOADSTORE = 2'd3
    } test_id_t;

    localparam logic [1:0] MW_NONE  = 2'b00;
    localparam logic [1:0] MW_WORD  = 2'b01;
    localparam logic [1:0] MW_DWORD = 2'b10;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        test_id_t    id;
    } sig_entry_t;

    localparam int NUM_SIGS = 3;

    localparam sig_entry_t SIG_STANDARD2 = '{addr: 64'd100, data: 64'd7, id: ID_STANDARD2};
    localparam sig_entry_t SIG_POWER2    = '{addr: 64'd128, data: 64'd7, id: ID_POWER2};
    localparam sig_entry_t SIG_LOADSTORE = '{addr: 64'd80,  data: 64'd1, id: ID_LOADSTORE};

    // Index 0 is the rightmost element of the concatenation.
    localparam sig_entry_t [NUM_SIGS-1:0] SIG_TABLE = {SIG_LOADSTORE, SIG_POWER2, SIG_STANDARD2};

endpackage

// File: rtl/store_result_monitor_sig_match.sv
// Combinational signature matcher: selects word/doubleword compare data and looks
// the store up in the signature table.
module sig_match
    import mips_mon_pkg::*;
(
    input  logic [1:0]  memwrite,
    input  logic [63:0] adr,
    input  logic [63:0] data,
    output logic        hit,
    output test_id_t    id
);

    logic                w_is_word;
    logic                w_is_dword;
    logic [63:0]         w_cmp_data;
    logic [NUM_SIGS-1:0] w_entry_hit;
    test_id_t            w_id;

    // Both 10 and 11 are doubleword stores, so only bit 1 decides.
    assign w_is_word  = (memwrite == MW_WORD);
    assign w_is_dword = ((memwrite & MW_DWORD) == MW_DWORD);
    assign w_cmp_data = w_is_dword ? data : {32'b0, data[31:0]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SIGS; gi++) begin : g_entry
            assign w_entry_hit[gi] = (adr == SIG_TABLE[gi].addr) &&
                                     (w_cmp_data == SIG_TABLE[gi].data);
        end
    endgenerate

    always_comb begin
        w_id = ID_NONE;
        for (int i = 0; i < NUM_SIGS; i++) begin
            if (w_entry_hit[i]) begin
                w_id = SIG_TABLE[i].id;
            end
        end
    end

    assign hit = (w_is_word || w_is_dword) && (|w_entry_hit);
    assign id  = hit ? w_id : ID_NONE;

endmodule

// File: rtl/store_result_monitor.sv
// Store-bus self-check monitor with cycle watchdog and sticky pass/fail verdict.
// Optional store counter is enabled by defining STORE_COUNT_EN.
module store_result_monitor
    import mips_mon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 512,
    parameter int DRAIN_CYCLES   = 10,
    parameter int CNT_W          = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [1:0]       memwrite,
    input  logic [63:0]      dataadr,
    input  logic [63:0]      writedata,
    output logic             halt,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       test_id,
    output logic [CNT_W-1:0] cycles,
    output logic [15:0]      store_count
);

    localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DR_W-1:0]  DRN_LAST = DR_W'(DRAIN_CYCLES - 1);

    mon_state_t       r_state;
    logic [CNT_W-1:0] r_cycles;
    logic [DR_W-1:0]  r_drain;
    logic             r_halt;
    logic             r_done;
    logic             r_pass;
    logic             r_fail;
    logic [1:0]       r_test_id;
    logic             w_hit;
    test_id_t         w_id;

    sig_match u_sig_match (
        .memwrite (memwrite),
        .adr      (dataadr),
        .data     (writedata),
        .hit      (w_hit),
        .id       (w_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RUN;
            r_cycles  <= '0;
            r_drain   <= '0;
            r_halt    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_test_id <= 2'd0;
        end else if (clear) begin
            r_state   <= ST_RUN;
            r_cycles  <= '0;
            r_drain   <= '0;
            r_halt    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_test_id <= 2'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // A match on the watchdog cycle still counts as a pass.
                    if (w_hit) begin
                        r_pass    <= 1'b1;
                        r_halt    <= 1'b1;
                        r_test_id <= w_id;
                        r_drain   <= '0;
                        r_state   <= ST_DRAIN;
                    end else if (r_cycles == CYC_LAST) begin
                        r_fail    <= 1'b1;
                        r_done    <= 1'b1;
                        r_halt    <= 1'b1;
                        r_test_id <= 2'd0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cycles <= r_cycles + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DRN_LAST) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign halt    = r_halt;
    assign done    = r_done;
    assign pass    = r_pass;
    assign fail    = r_fail;
    assign test_id = r_test_id;
    assign cycles  = r_cycles;

`ifdef STORE_COUNT_EN
    logic [15:0] r_store_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_store_count <= 16'd0;
        end else if (clear) begin
            r_store_count <= 16'd0;
        end else if ((r_state == ST_RUN) && (memwrite != MW_NONE) &&
                     (r_store_count != 16'hFFFF)) begin
            r_store_count <= r_store_count + 16'd1;
        end
    end

    assign store_count = r_store_count;
`else
    assign store_count = 16'd0;
`endif

endmodule

// File: tb/tb_store_result_monitor.sv
// Randomized bench for store_result_monitor; expected outputs come from a run-level
// model (first matching store index, drain length, watchdog limit).
module tb_store_result_monitor;

    localparam int TIMEOUT = 512;
    localparam int DRAIN   = 10;
    localparam int MAXN    = 600;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [1:0]  memwrite = 2'b00;
    logic [63:0] dataadr = 64'd0;
    logic [63:0] writedata = 64'd0;
    logic        halt, done, pass, fail;
    logic [1:0]  test_id;
    logic [9:0]  cycles;
    logic [15:0] store_count;

    int n_err = 0;
    int n_checks = 0;

    logic [1:0]  stim_mw   [MAXN];
    logic [63:0] stim_adr  [MAXN];
    logic [63:0] stim_data [MAXN];
    int          pre       [MAXN+1];
    logic [31:0] obs       [MAXN+1];
    int          m_k;
    int          m_id;

    always #5 clk = ~clk;

    store_result_monitor #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .DRAIN_CYCLES   (DRAIN),
        .CNT_W          (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .halt        (halt),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .test_id     (test_id),
        .cycles      (cycles),
        .store_count (store_count)
    );

    function automatic logic [31:0] cur_vec();
        return {halt, done, pass, fail, test_id, cycles, store_count};
    endfunction

    function automatic int model_id(input logic [1:0] mw, input logic [63:0] a, input logic [63:0] d);
        logic [63:0] v;
        if (mw == 2'b00) return 0;
        v = mw[1] ? d : {32'h0, d[31:0]};
        if (a == 64'd100 && v == 64'd7) return 1;
        if (a == 64'd128 && v == 64'd7) return 2;
        if (a == 64'd80  && v == 64'd1) return 3;
        return 0;
    endfunction

    // Expected output vector after the e-th clock edge of a run.
    function automatic logic [31:0] exp_vec(input int e);
        bit h, d, p, f;
        int tid, cyc, last, upto, sc;
        if (m_k >= 0) begin
            p = (e >= m_k + 1);
            h = p;
            d = (e >= m_k + 1 + DRAIN);
            f = 1'b0;
            tid = p ? m_id : 0;
            cyc = (e < m_k) ? e : m_k;
            last = m_k;
        end else begin
            f = (e >= TIMEOUT);
            d = f;
            h = f;
            p = 1'b0;
            tid = 0;
            cyc = (e < TIMEOUT - 1) ? e : TIMEOUT - 1;
            last = TIMEOUT - 1;
        end
        upto = (e - 1 < last) ? e - 1 : last;
`ifdef STORE_COUNT_EN
        sc = pre[upto + 1];
`else
        sc = 0;
`endif
        return {h, d, p, f, tid[1:0], cyc[9:0], sc[15:0]};
    endfunction

    task automatic analyze();
        m_k = -1;
        m_id = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (model_id(stim_mw[i], stim_adr[i], stim_data[i]) != 0) begin
                m_k = i;
                m_id = model_id(stim_mw[i], stim_adr[i], stim_data[i]);
                break;
            end
        end
        pre[0] = 0;
        for (int i = 0; i < MAXN; i++) pre[i+1] = pre[i] + ((stim_mw[i] != 2'b00) ? 1 : 0);
    endtask

    task automatic fill_idle();
        for (int i = 0; i < MAXN; i++) begin
            stim_mw[i] = 2'b00;
            stim_adr[i] = 64'd0;
            stim_data[i] = 64'd0;
        end
    endtask

    // Non-matching stores, biased toward near misses on the signature fields.
    task automatic fill_noise(input int density);
        for (int i = 0; i < MAXN; i++) begin
            do begin
                stim_mw[i] = ($urandom_range(0, 99) < density) ? 2'($urandom_range(1, 3)) : 2'b00;
                case ($urandom_range(0, 3))
                    0: stim_adr[i] = 64'd100;
                    1: stim_adr[i] = 64'd128;
                    2: stim_adr[i] = 64'd80;
                    default: stim_adr[i] = {$urandom, $urandom};
                endcase
                case ($urandom_range(0, 4))
                    0: stim_data[i] = 64'd7;
                    1: stim_data[i] = 64'd1;
                    2: stim_data[i] = {$urandom, 32'd7};
                    3: stim_data[i] = {$urandom, 32'd1};
                    default: stim_data[i] = {$urandom, $urandom};
                endcase
            end while (model_id(stim_mw[i], stim_adr[i], stim_data[i]) != 0);
        end
    endtask

    task automatic start_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drive_run(input int n);
        for (int e = 1; e <= n; e++) begin
            memwrite  = stim_mw[e-1];
            dataadr   = stim_adr[e-1];
            writedata = stim_data[e-1];
            @(posedge clk);
            #1;
            obs[e] = cur_vec();
        end
        memwrite = 2'b00;
    endtask

    task automatic test_reset();
        memwrite = 2'b10;
        dataadr = 64'd100;
        writedata = 64'd7;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (cur_vec() !== 32'd0) begin
            n_err++;
            $display("FAIL reset_async: got %h expected %h", cur_vec(), 32'd0);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cur_vec() !== 32'd0) begin
            n_err++;
            $display("FAIL reset_held: got %h expected %h", cur_vec(), 32'd0);
        end
        memwrite = 2'b00;
        reset = 1'b1;
        $display("test_reset: outputs zero under reset");
    endtask

    task automatic test_dword_match();
        fill_noise(50);
        stim_mw[40] = 2'b10; stim_adr[40] = 64'd100; stim_data[40] = 64'd7;
        analyze();
        start_reset();
        drive_run(60);
        for (int e = 1; e <= 60; e++) begin
            n_checks++;
            if (obs[e] !== exp_vec(e)) begin
                n_err++;
                $display("FAIL dword_match cycle %0d: got %h expected %h", e, obs[e], exp_vec(e));
            end
        end
        n_checks++;
        if ({obs[41][29], obs[41][27:26], obs[50][30], obs[51][30], obs[60][25:16]} !== {1'b1, 2'd1, 1'b0, 1'b1, 10'd40}) begin
            n_err++;
            $display("FAIL dword_match_timing: pass41=%b id41=%0d done50=%b done51=%b cycles=%0d expected 1 1 0 1 40",
                     obs[41][29], obs[41][27:26], obs[50][30], obs[51][30], obs[60][25:16]);
        end
        $display("test_dword_match: match at 40, id=%0d cycles=%0d", obs[60][27:26], obs[60][25:16]);
    endtask

    task automatic test_word_upper_ignored();
        fill_noise(30);
        stim_mw[20] = 2'b11; stim_adr[20] = 64'd80; stim_data[20] = 64'hFFFF_FFFF_0000_0001;
        stim_mw[30] = 2'b01; stim_adr[30] = 64'd80; stim_data[30] = 64'hFFFF_FFFF_0000_0001;
        analyze();
        start_reset();
        drive_run(50);
        for (int e = 1; e <= 50; e++) begin
            n_checks++;
            if (obs[e] !== exp_vec(e)) begin
                n_err++;
                $display("FAIL word_upper cycle %0d: got %h expected %h", e, obs[e], exp_vec(e));
            end
        end
        n_checks++;
        if ({obs[21][29], obs[31][29], obs[31][27:26]} !== {1'b0, 1'b1, 2'd3}) begin
            n_err++;
            $display("FAIL word_upper_id: pass21=%b pass31=%b id31=%0d expected 0 1 3",
                     obs[21][29], obs[31][29], obs[31][27:26]);
        end
        $display("test_word_upper_ignored: id=%0d", obs[50][27:26]);
    endtask

    task automatic test_watchdog();
        fill_noise(60);
        analyze();
        start_reset();
        drive_run(520);
        for (int e = 1; e <= 520; e++) begin
            n_checks++;
            if (obs[e] !== exp_vec(e)) begin
                n_err++;
                $display("FAIL watchdog cycle %0d: got %h expected %h", e, obs[e], exp_vec(e));
            end
        end
        n_checks++;
        if ({obs[511][31:28], obs[512][31:26], obs[520][25:16]} !== {4'b0000, 4'b1101, 2'd0, 10'd511}) begin
            n_err++;
            $display("FAIL watchdog_edge: hdpf511=%b hdpf512=%b id=%0d cycles=%0d expected 0000 1101 0 511",
                     obs[511][31:28], obs[512][31:28], obs[512][27:26], obs[520][25:16]);
        end
        $display("test_watchdog: fail=%b cycles=%0d", obs[520][28], obs[520][25:16]);
    endtask

    task automatic test_pass_on_watchdog();
        fill_noise(40);
        stim_mw[511] = 2'b10; stim_adr[511] = 64'd128; stim_data[511] = 64'd7;
        analyze();
        start_reset();
        drive_run(530);
        for (int e = 1; e <= 530; e++) begin
            n_checks++;
            if (obs[e] !== exp_vec(e)) begin
                n_err++;
                $display("FAIL pass_on_watchdog cycle %0d: got %h expected %h", e, obs[e], exp_vec(e));
            end
        end
        n_checks++;
        if ({obs[512][29], obs[512][28], obs[512][27:26]} !== {1'b1, 1'b0, 2'd2}) begin
            n_err++;
            $display("FAIL pass_wins: pass=%b fail=%b id=%0d expected 1 0 2",
                     obs[512][29], obs[512][28], obs[512][27:26]);
        end
        $display("test_pass_on_watchdog: pass=%b fail=%b id=%0d", obs[530][29], obs[530][28], obs[530][27:26]);
    endtask

    task automatic test_drain_ignore_and_clear();
        int k;
        k = $urandom_range(5, 100);
        fill_noise(50);
        stim_mw[k] = 2'b01; stim_adr[k] = 64'd80; stim_data[k] = {$urandom, 32'd1};
        stim_mw[k+3] = 2'b10; stim_adr[k+3] = 64'd100; stim_data[k+3] = 64'd7;
        analyze();
        start_reset();
        drive_run(k + 20);
        for (int e = 1; e <= k + 20; e++) begin
            n_checks++;
            if (obs[e] !== exp_vec(e)) begin
                n_err++;
                $display("FAIL drain_ignore cycle %0d: got %h expected %h", e, obs[e], exp_vec(e));
            end
        end
        n_checks++;
        if (obs[k+20][27:26] !== 2'd3) begin
            n_err++;
            $display("FAIL drain_ignore_id: got %0d expected 3", obs[k+20][27:26]);
        end
        // Clear in DONE, with a matching store on the bus the same cycle.
        clear = 1'b1;
        memwrite = 2'b10; dataadr = 64'd128; writedata = 64'd7;
        @(posedge clk);
        #1;
        clear = 1'b0;
        memwrite = 2'b00;
        n_checks++;
        if (cur_vec() !== 32'd0) begin
            n_err++;
            $display("FAIL clear_in_done: got %h expected %h", cur_vec(), 32'd0);
        end
        $display("test_drain_ignore_and_clear: match at %0d, id kept=%0d", k, obs[k+20][27:26]);
    endtask

    task automatic test_store_count();
        fill_idle();
        for (int i = 0; i < 5; i++) begin
            stim_mw[2*i] = 2'b01; stim_adr[2*i] = 64'd100; stim_data[2*i] = 64'd8 + 64'(i);
        end
        stim_mw[12] = 2'b10; stim_adr[12] = 64'd128; stim_data[12] = 64'd7;
        stim_mw[14] = 2'b10; stim_adr[14] = 64'd64; stim_data[14] = 64'd3;
        analyze();
        start_reset();
        drive_run(30);
        n_checks++;
`ifdef STORE_COUNT_EN
        if (obs[30][15:0] !== 16'd6) begin
            n_err++;
            $display("FAIL store_count: got %0d expected 6", obs[30][15:0]);
        end
`else
        if (obs[30][15:0] !== 16'd0) begin
            n_err++;
            $display("FAIL store_count: got %0d expected 0", obs[30][15:0]);
        end
`endif
        for (int e = 1; e <= 30; e++) begin
            n_checks++;
            if (obs[e] !== exp_vec(e)) begin
                n_err++;
                $display("FAIL store_count_run cycle %0d: got %h expected %h", e, obs[e], exp_vec(e));
            end
        end
        $display("test_store_count: store_count=%0d", obs[30][15:0]);
    endtask

    task automatic test_random();
        int k, id, n;
        for (int it = 0; it < 4; it++) begin
            k = $urandom_range(0, 560);
            id = $urandom_range(1, 3);
            fill_noise($urandom_range(10, 90));
            if (k < TIMEOUT) begin
                stim_mw[k] = 2'($urandom_range(1, 3));
                stim_adr[k] = (id == 1) ? 64'd100 : (id == 2) ? 64'd128 : 64'd80;
                stim_data[k] = {((stim_mw[k] == 2'b01) ? $urandom : 32'd0), ((id == 3) ? 32'd1 : 32'd7)};
            end
            analyze();
            // First iteration starts from the RUN state left by the preceding clear.
            if (it != 0) start_reset();
            n = (m_k >= 0) ? m_k + DRAIN + 5 : TIMEOUT + 5;
            drive_run(n);
            for (int e = 1; e <= n; e++) begin
                n_checks++;
                if (obs[e] !== exp_vec(e)) begin
                    n_err++;
                    $display("FAIL random%0d cycle %0d: got %h expected %h", it, e, obs[e], exp_vec(e));
                end
            end
            $display("test_random%0d: match_at=%0d id=%0d final=%h", it, m_k, m_id, obs[n]);
        end
    endtask

    task automatic test_reset_mid_drain();
        fill_noise(50);
        stim_mw[7] = 2'b10; stim_adr[7] = 64'd100; stim_data[7] = 64'd7;
        analyze();
        start_reset();
        drive_run(11);
        n_checks++;
        if (obs[11] !== exp_vec(11)) begin
            n_err++;
            $display("FAIL mid_drain_pre: got %h expected %h", obs[11], exp_vec(11));
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (cur_vec() !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_drain: got %h expected %h", cur_vec(), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        $display("test_reset_mid_drain: outputs=%h", cur_vec());
    endtask

    initial begin
        test_reset();
        test_dword_match();
        test_word_upper_ignored();
        test_watchdog();
        test_pass_on_watchdog();
        test_drain_ignore_and_clear();
        test_random();
        test_store_count();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/store_result_monitor.md
# store_result_monitor

Synthesizable self-check monitor downstream of the 64-bit MIPS `top`. It consumes the data-memory store bus (`memwrite`, `dataadr`, `writedata`), matches stores against the known end-of-program result signatures, and bounds run length with a cycle watchdog. It reports a sticky pass/fail verdict with a test ID, so FPGA builds and benches read the same verdict without `$stop`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 512: run cycles before a fail verdict.
- `DRAIN_CYCLES`, 10: cycles between a signature match and `done`.
- `CNT_W`, 10: cycle-counter width; must satisfy 2^CNT_W ≥ TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous restart: return to RUN and zero all counters.
- `memwrite`  in  2  store strobe. 00 = none, 01 = word store, 10 or 11 = doubleword store.
- `dataadr`  in  64  store byte address.
- `writedata`  in  64  store data.
- `halt`  out  1  asks the core to freeze; high in DRAIN and DONE.
- `done`  out  1  verdict valid (sticky).
- `pass`  out  1  signature matched (sticky).
- `fail`  out  1  watchdog expired (sticky).
- `test_id`  out  2  0 none, 1 standard2, 2 power2, 3 loadstore.
- `cycles`  out  CNT_W  run cycles elapsed, frozen at verdict.
- `store_count`  out  16  stores seen (see Configuration).

## Operation
- States: RUN, DRAIN, DONE.
- Reset (`reset`=0): state RUN. All outputs and counters are 0.
- RUN:
  - `cycles` increments once per clock.
  - A store is any cycle with `memwrite` ≠ 00.
  - Comparison data is `writedata` for a doubleword store. For a word store it is `{32'b0, writedata[31:0]}`.
  - Signatures, checked with exact 64-bit equality: (addr 100, data 7) gives id 1. (addr 128, data 7) gives id 2. (addr 80, data 1) gives id 3.
  - On a match: latch `test_id`, set `pass`, freeze `cycles`, go to DRAIN.
  - Non-matching stores are ignored.
  - If `cycles` = TIMEOUT_CYCLES−1 and there is no match that cycle: set `fail`, `test_id`=0, go to DONE.
  - A match and the watchdog expiring in the same cycle is resolved as a match (pass wins).
- DRAIN:
  - Counts DRAIN_CYCLES clocks, then goes to DONE.
  - Stores arriving here are ignored, so a second match does not change `test_id`.
- DONE: terminal until `clear` or reset. Outputs are held.
- `clear`: takes priority over every transition. Next state is RUN; all outputs and counters return to their reset values.
- Reset asserted mid-run, mid-drain or in DONE: immediate asynchronous return to reset values.
- `cycles` never wraps, because the watchdog fires at TIMEOUT_CYCLES−1 < 2^CNT_W.

## Timing
- Store bus is sampled at the rising edge.
- `pass`, `test_id` and `halt` go high the edge after the matching store is sampled: latency 1.
- `done` rises exactly DRAIN_CYCLES clocks after `pass`.
- `fail`, `done` and `halt` rise together at the edge on which `cycles` would reach TIMEOUT_CYCLES. With defaults, that is 512 clocks after reset release.
- Outputs are registered only; there are no combinational input-to-output paths.

## Configuration
- `STORE_COUNT_EN` defined: `store_count` increments on each store accepted in RUN, saturating at 16'hFFFF.
- `STORE_COUNT_EN` not defined: the counter logic is removed and `store_count` is tied to 0.
- The port exists in both builds.

## Structure
- Package `mips_mon_pkg` holds:
  - `mon_state_t` (RUN/DRAIN/DONE);
  - `test_id_t`;
  - the signature table as typed constants: address, data and ID per entry;
  - the memwrite encodings `MW_NONE`, `MW_WORD`, `MW_DWORD`.
- Sub-module `sig_match`: combinational. Inputs are the memwrite encoding, address and data; outputs are `hit` and `id`. It does the word/doubleword data selection and the table lookup.

## Test plan
- Reset release, then doubleword store addr 100 data 7 at cycle 40 → `pass`=1, `test_id`=1 at cycle 41; `done`=1 at cycle 51; `cycles`=40.
- Word store addr 80, `writedata`=64'hFFFF_FFFF_0000_0001 → match with `test_id`=3, because the upper half is ignored. The same value as a doubleword store → no match.
- No matching store → `fail`=`done`=`halt`=1 after 512 clocks, `test_id`=0, `cycles`=511.
- Store addr 128 data 7 on the watchdog cycle → `pass`=1, `fail`=0, `test_id`=2.
- Match, then store addr 100 data 7 during DRAIN → `test_id` unchanged. Pulse `clear` in DONE → all outputs 0, state RUN. Assert `reset` mid-DRAIN → outputs 0 without waiting for a clock edge.
- With `STORE_COUNT_EN`, 5 non-matching stores then a match → `store_count`=6. Without the macro → `store_count`=0.
